// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit that stalls the pipeline for 34 cycles per operation
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
   state_t                  state_q;
   logic [2:0]              op_q;
   logic [XLEN-1:0]         a_q, b_q, result_q;
   logic [2*XLEN-1:0]       acc_q;
   logic [$clog2(XLEN)-1:0] cnt_q;
   logic                    neg_q, neg_a_q, busy_q, done_q;
   logic                    a_neg, b_neg, div_zero, div_ovf, early;
   logic [XLEN-1:0]         a_mag, b_mag, early_res, quo, rem, res_d;
   logic [2*XLEN-1:0]       mul_d, div_d, prod;
   logic [XLEN:0]           rem_sh, diff;
   always_comb begin
      a_neg     = rs1_value[XLEN-1] & (funct3 == 3'b001 | funct3 == 3'b010 | funct3 == 3'b100 | funct3 == 3'b110);
      b_neg     = rs2_value[XLEN-1] & (funct3 == 3'b001 | funct3 == 3'b100 | funct3 == 3'b110);
      a_mag     = a_neg ? -rs1_value : rs1_value;
      b_mag     = b_neg ? -rs2_value : rs2_value;
      div_zero  = funct3[2] & (rs2_value == '0);
      div_ovf   = funct3[2] & ~funct3[0] & (rs1_value == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_value);
      early     = div_zero | div_ovf;
      early_res = div_zero ? (funct3[1] ? rs1_value : '1) : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
      mul_d     = acc_q + (b_q[cnt_q] ? ({{XLEN{1'b0}}, a_q} << cnt_q) : '0);
      rem_sh    = {acc_q[2*XLEN-1:XLEN], a_q[~cnt_q]};
      diff      = rem_sh - {1'b0, b_q};
      div_d     = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      prod      = neg_q ? -acc_q : acc_q;
      quo       = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem       = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      res_d     = op_q[2] ? (op_q[1] ? rem : quo)
                          : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end
   assign stall  = (state_q == IDLE && start && !flush) || state_q == CALC || state_q == FIXUP;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         neg_a_q  <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (flush && state_q != IDLE) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start && !flush) begin
               op_q    <= funct3;
               a_q     <= a_mag;
               b_q     <= b_mag;
               neg_q   <= a_neg ^ b_neg;
               neg_a_q <= a_neg;
               acc_q   <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               if (early) begin
                  result_q <= early_res;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= op_q[2] ? div_d : mul_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) state_q <= FIXUP;
            end
            FIXUP: begin
               result_q <= res_d;
               done_q   <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer against a cycle-level reference model
module tb_muldiv_sequencer;
   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_value, rs2_value;
   logic        busy, stall, done;
   logic [31:0] result;
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic [31:0] last_exp = '0;
   int          m_left = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_res = '0, m_pend = '0;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_value(rs1_value), .rs2_value(rs2_value), .flush(flush),
      .busy(busy), .stall(stall), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      int          sa, sb;
      logic        ovf;
      ea  = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
      eb  = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
      p   = ea * eb;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'b000:                 return p[31:0];
         3'b001, 3'b010, 3'b011: return p[63:32];
         3'b100:                 return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         3'b101:                 return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:                 return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default:                return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected-behaviour model: an op is pending for 33 cycles (or 0 if it exits early), then done for one.
   always @(posedge clk) begin
      if (rst) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
      end else if (flush && (m_left > 0 || m_done)) begin
         m_left <= 0;
         m_done <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 1) begin
         m_left <= m_left - 1;
      end else if (m_left == 1) begin
         m_left <= 0;
         m_done <= 1'b1;
         m_res  <= m_pend;
      end else if (start && !flush) begin
         if (is_early(funct3, rs1_value, rs2_value)) begin
            m_done <= 1'b1;
            m_res  <= ref_result(funct3, rs1_value, rs2_value);
         end else begin
            m_left <= 33;
            m_pend <= ref_result(funct3, rs1_value, rs2_value);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_left > 0 || m_done));
         chk("done", 32'(done), 32'(m_done));
         chk("stall", 32'(stall), 32'((m_left == 0 && !m_done && start && !flush) || m_left > 0));
         chk("result", result, m_res);
      end
   end

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int poke, input string nm);
      int n;
      @(posedge clk); #1;
      start = 1'b1; funct3 = f; rs1_value = a; rs2_value = b;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (done) break;
         if (n == poke) begin
            #1 start = 1'b1; funct3 = 3'b000; rs1_value = 32'd1; rs2_value = 32'd1;
         end else if (n == poke + 1) begin
            #1 start = 1'b0;
         end
      end
      chk({"lat_", nm}, 32'(n), 32'(lat));
      chk({"res_", nm}, result, exp);
      last_exp = exp;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_value = '0; rs2_value = '0;
      @(posedge clk); #1 chk_en = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_result", result, 32'h0);
      chk("pin_mul", ref_result(3'b000, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      chk("pin_mulhsu", ref_result(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
      chk("pin_rem", ref_result(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, "mul");
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, "mulh");
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu");
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "mulhsu");
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, "div");
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, "rem");
      run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 0, "divu");
      run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, 0, "remu");
      run_op(3'b101, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_zero");
      run_op(3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0, "rem_zero");
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, "rem_ovf");
      // flush during CALC at T+10
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'b000; rs1_value = 32'd9; rs2_value = 32'd9;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(busy), 32'h0);
      chk("flush_done", 32'(done), 32'h0);
      chk("flush_result", result, last_exp);
      run_op(3'b000, 32'd3, 32'd5, 32'd15, 34, 0, "mul_after_flush");
      // reset at T+20
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'b001; rs1_value = 32'h1234_5678; rs2_value = 32'h9ABC_DEF0;
      @(posedge clk); #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      chk("midrst_result", result, 32'h0);
      run_op(3'b011, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 34, 0, "mulhu_after_rst");
      run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 5, "ignored_start");
      repeat (3000) begin
         @(posedge clk); #1;
         start     = ($urandom_range(0, 3) == 0);
         funct3    = 3'($urandom());
         rs1_value = rnd_op();
         rs2_value = rnd_op();
         flush     = ($urandom_range(0, 99) == 0);
         rst       = ($urandom_range(0, 999) == 0);
      end
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
